// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: ROM window, instruction width,
// and the {pc, word} entry carried through the prefetch queue.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_ROM      = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] ROM_SIZE      = 32'h0002_0000;
    localparam logic [ADDR_W-1:0] ROM_LAST_WORD = ADDR_ROM + ROM_SIZE - 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; low two bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous prefetch FIFO of {pc, word} entries with push, pop and
// flush. Push while full is accepted only when a pop frees the head slot in
// the same cycle. Flush has priority over push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     slots [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
    assign head    = slots[head_ptr];

    // Entry storage has no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            slots[tail_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; flush empties the queue and rewinds both pointers.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (do_pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, drives the code port address,
// queues returned words for decode, handles redirect/flush and raises a
// sticky fault once the PC leaves the ROM window.
// Optional feature macro: FETCH_PERF_CNT_EN adds the stall_cycles counter/port.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] ROM_LAST    = ROM_LAST_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] code_addr,
    input  logic [31:0] r_code,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [31:0]      fetch_pc;
    logic             fault;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             in_rom;
    logic             has_room;
    logic             push;
    logic             pop;

    assign in_rom      = (fetch_pc <= ROM_LAST);
    assign instr_valid = (count != '0);
    // A handshake in a redirect cycle is discarded, so it never pops.
    assign pop         = instr_valid && instr_ready && !redirect_en;
    assign has_room    = (count < CNT_W'(QUEUE_DEPTH)) || pop;
    assign push        = !redirect_en && !fault && in_rom && has_room;
    assign push_entry  = '{pc: fetch_pc, word: r_code};

    assign code_addr   = fetch_pc;
    assign instr       = instr_valid ? head.word : '0;
    assign instr_pc    = instr_valid ? head.pc   : '0;
    assign fetch_fault = fault;

    fetch_queue #(
        .DEPTH      (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_en),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    // Fetch PC: reset, redirect target, or advance one word per accepted fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_en) begin
            fetch_pc <= word_align(redirect_pc);
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Sticky fault once the PC is past the ROM; only reset or redirect clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (redirect_en) begin
            fault <= 1'b0;
        end else if (!fault && !in_rom) begin
            fault <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count cycles where decode is starved but fetch is not faulted; saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!instr_valid && !fault && (stall_cycles != 32'hffff_ffff)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
